// File: rtl/button_conditioner.sv
// Synchronizes, debounces and edge-detects four raw pushbuttons; a held change reaches btn_level after DEBOUNCE_COUNT+2 edges.
// No backpressure: press flags stay latched until rd_strobe clears them, and a press landing on the clearing edge wins.
module button_conditioner #(
  parameter int unsigned DEBOUNCE_COUNT = 16'd50_000,
  parameter int unsigned CNT_W          = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] btn_raw,
  input  logic       rd_strobe,
  output logic [3:0] btn_level,
  output logic [3:0] btn_press,
  output logic       press_any
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_COUNT - 1);

  logic [3:0]       s1;
  logic [3:0]       s2;
  logic [3:0]       stable;
  logic [3:0]       stable_nxt;
  logic [3:0]       rise;
  logic [3:0]       press_nxt;
  logic [CNT_W-1:0] cnt     [4];
  logic [CNT_W-1:0] cnt_nxt [4];

  // A counter only advances while the synchronized input disagrees with the
  // accepted level; any agreement (a glitch ending) drops it back to zero.
  always_comb begin
    stable_nxt = stable;
    rise       = '0;
    for (int i = 0; i < 4; i++) begin
      cnt_nxt[i] = '0;
      if (s2[i] != stable[i]) begin
        if (cnt[i] == CNT_MAX) begin
          stable_nxt[i] = s2[i];
          rise[i]       = s2[i];
        end else begin
          cnt_nxt[i] = cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  assign press_nxt = (btn_press & {4{~rd_strobe}}) | rise;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1        <= '0;
      s2        <= '0;
      stable    <= '0;
      btn_press <= '0;
      for (int i = 0; i < 4; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      s1        <= btn_raw;
      s2        <= s1;
      stable    <= stable_nxt;
      btn_press <= press_nxt;
      for (int i = 0; i < 4; i++) begin
        cnt[i] <= cnt_nxt[i];
      end
    end
  end

  assign btn_level = stable;
  assign press_any = |btn_press;

endmodule
